// File: rtl/minion_sprite_fetch_arb.sv
`default_nettype none
// ============================================================================
// Module   : minion_sprite_fetch_arb
// Purpose  : Shares one combinational sprite ROM port among N_REQ minion draw
//            engines. A round-robin arbiter accepts one sprite-row request at
//            a time and streams that row's SPR_W pixels out through a
//            registered valid/ready stage.
// Options  : MINION_ARB_FIXED_PRIO_EN - when defined, the lowest-index active
//            requester always wins and the round-robin pointer is removed.
// Revision : 1.0 - initial release
// ============================================================================
module minion_sprite_fetch_arb #(
  parameter int N_REQ    = 4,
  parameter int SPR_W    = 32,
  parameter int SPR_H    = 53,
  parameter int ROW_BITS = 6
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*ROW_BITS-1:0] req_row,
  output logic [N_REQ-1:0]          gnt,
  output logic [18:0]               rom_addr,
  input  logic [2:0]                rom_data,
  output logic                      pix_valid,
  input  logic                      pix_ready,
  output logic [2:0]                pix_data,
  output logic [4:0]                pix_col,
  output logic [2:0]                pix_owner,
  output logic                      burst_done,
  output logic                      busy
);

  localparam logic [4:0]       C_LAST_COL = 5'(SPR_W - 1);
  localparam logic [N_REQ-1:0] C_ONE      = {{(N_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t              r_state;
  logic [ROW_BITS-1:0] r_row;
  logic [4:0]          r_col;
  logic [2:0]          w_win;
  logic [ROW_BITS-1:0] w_row_sel;
  logic                w_row_ok;
  logic                w_capture;
`ifndef MINION_ARB_FIXED_PRIO_EN
  logic [2:0]          r_last;
  logic                w_hi_found;
  logic [2:0]          w_hi_idx;
  logic [2:0]          w_lo_idx;
`endif

  // Winner selection: lowest active index, or, in round-robin mode, the lowest
  // active index above the last winner with wrap back to the lowest overall.
  always_comb begin
    w_win = '0;
`ifdef MINION_ARB_FIXED_PRIO_EN
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (req[j]) w_win = 3'(j);
    end
`else
    w_hi_found = 1'b0;
    w_hi_idx   = '0;
    w_lo_idx   = '0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (req[j]) w_lo_idx = 3'(j);
      if (req[j] && (3'(j) > r_last)) begin
        w_hi_found = 1'b1;
        w_hi_idx   = 3'(j);
      end
    end
    w_win = w_hi_found ? w_hi_idx : w_lo_idx;
`endif
  end

  // Row index belonging to the selected winner.
  always_comb begin
    w_row_sel = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (3'(j) == w_win) w_row_sel = req_row[j*ROW_BITS +: ROW_BITS];
    end
  end

  assign w_row_ok  = (32'(r_row) < 32'(SPR_H));
  assign w_capture = !pix_valid || pix_ready;
  assign busy      = (r_state != ST_IDLE);

  // ROM address; out-of-range rows park the address at zero for the burst.
  always_comb begin
    rom_addr = '0;
    if ((r_state != ST_IDLE) && w_row_ok) begin
      rom_addr = 19'(r_row) * 19'(SPR_W) + 19'(r_col);
    end
  end

  // Arbitration / burst FSM with registered grant and pixel outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state    <= ST_IDLE;
      r_row      <= '0;
      r_col      <= '0;
      gnt        <= '0;
      pix_valid  <= 1'b0;
      pix_data   <= '0;
      pix_col    <= '0;
      pix_owner  <= '0;
      burst_done <= 1'b0;
`ifndef MINION_ARB_FIXED_PRIO_EN
      r_last     <= 3'(N_REQ - 1);
`endif
    end else begin
      gnt        <= '0;
      burst_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (|req) begin
            gnt       <= C_ONE << w_win;
            r_row     <= w_row_sel;
            pix_owner <= w_win;
            r_col     <= '0;
`ifndef MINION_ARB_FIXED_PRIO_EN
            r_last    <= w_win;
`endif
            r_state   <= ST_BURST;
          end
        end
        ST_BURST: begin
          if (w_capture) begin
            pix_data  <= w_row_ok ? rom_data : 3'd0;
            pix_col   <= r_col;
            pix_valid <= 1'b1;
            // The column parks on the last pixel so the address stays put in DRAIN.
            if (r_col == C_LAST_COL) begin
              r_state <= ST_DRAIN;
            end else begin
              r_col <= r_col + 5'd1;
            end
          end
        end
        ST_DRAIN: begin
          if (pix_valid && pix_ready) begin
            pix_valid  <= 1'b0;
            burst_done <= 1'b1;
            r_state    <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
